// File: rtl/fb_pkg.sv
// Shared framebuffer constants and types.
//
// Used by the framebuffer writer and by the drawing blocks (erase, sprite
// draw, score draw) that produce the pixel-plot stream. It holds the screen
// geometry, the field widths, the pixel record and the linear-address helper.
package fb_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ADDR_W   = 15;
  localparam int COLOR_W  = 3;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] c;
  } pixel_t;

  // Linear address y*160 + x. 160 = 128 + 32, so two shifts and two adds
  // replace a multiplier. The result fits in 15 bits (max 119*160+159 = 19199).
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;
    x_ext = {{(ADDR_W-X_W){1'b0}}, x};
    y_ext = {{(ADDR_W-Y_W){1'b0}}, y};
    return (y_ext << 7) + (y_ext << 5) + x_ext;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel_t records.
//
// Ports:
//   clk_i    - clock, all state updates on the rising edge
//   reset_i  - synchronous active-high reset; empties the FIFO
//   push_i   - write data_i at the tail (ignored when full)
//   data_i   - pixel to write
//   pop_i    - drop the head entry (ignored when empty)
//   data_o   - head entry, valid whenever empty_o is 0
//   full_o   - count == DEPTH
//   empty_o  - count == 0
//   count_o  - number of stored entries
//
// DEPTH must be a power of two, so the pointers wrap naturally.
module pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  pixel_t           data_i,
  input  logic             pop_i,
  output pixel_t           data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  pixel_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    // A simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Framebuffer writer: receiving end of the pixel-plot stream.
//
// Pixels (x, y, colour) arrive over a valid/ready handshake and are buffered
// in a small FIFO. The head pixel is range-checked; on-screen pixels become a
// single-cycle write (mem_addr = y*160 + x, mem_data = colour) held in one
// output register stage with mem_ready back-pressure. Off-screen pixels are
// discarded and counted in a saturating 8-bit counter.
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   in_x, in_y, in_c    - incoming pixel column, row and colour
//   in_valid, in_ready  - input handshake (push when both high)
//   mem_addr, mem_data  - framebuffer write address and colour
//   mem_we, mem_ready   - write strobe and memory acceptance
//   idle                - FIFO empty and no pending write
//   drop_count          - saturating count of discarded off-screen pixels
//
// COLOR_W must equal fb_pkg::COLOR_W, since the buffered pixel record uses it.
module framebuffer_writer #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int FIFO_DEPTH = 4,
  parameter int COLOR_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_x,
  input  logic [6:0]         in_y,
  input  logic [COLOR_W-1:0] in_c,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [14:0]        mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic               idle,
  output logic [7:0]         drop_count
);
  import fb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_W-1:0] X_LIMIT = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(SCREEN_H);

  pixel_t             in_pix;
  pixel_t             head_pix;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               push;
  logic               pop;
  logic               adv;
  logic               on_screen;

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               we_q, we_d;
  logic [7:0]         drop_q, drop_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_pix = '{x: in_x, y: in_y, c: in_c};

  // in_ready depends only on registered occupancy (and reset), never on
  // mem_ready, so a full FIFO refuses input even on a cycle it also pops.
  assign in_ready = !reset && !fifo_full;
  assign push     = in_valid && in_ready;

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (push),
    .data_i (in_pix),
    .pop_i  (pop),
    .data_o (head_pix),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // ---- FIFO head -> output register ----
  // The output stage advances when it holds no write or the memory takes it.
  // A pixel pushed into an empty FIFO is not bypassed; it is popped next edge.
  assign adv       = !we_q || mem_ready;
  assign pop       = adv && !fifo_empty;
  assign on_screen = (head_pix.x < X_LIMIT) && (head_pix.y < Y_LIMIT);

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    we_d   = we_q;
    drop_d = drop_q;
    if (adv) begin
      if (!fifo_empty) begin
        if (on_screen) begin
          addr_d = fb_addr(head_pix.x, head_pix.y);
          data_d = head_pix.c;
          we_d   = 1'b1;
        end else begin
          we_d   = 1'b0;
          drop_d = sat_inc8(drop_q);
        end
      end else begin
        // Nothing to issue: address and data keep their last values.
        we_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      drop_q <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
      drop_q <= drop_d;
    end
  end

  // ---- outputs ----
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign mem_we     = we_q;
  assign drop_count = drop_q;
  assign idle       = (fifo_count == '0) && !we_q;

endmodule
